// File: rtl/nios_data_out_ch1.sv
// nios_data_out_ch1: Avalon-MM write-side FIFO feeding a valid/ready stream.
// Nios writes 10-bit words into a first-word-fall-through FIFO. Status and
// control registers expose the fill level, a sticky overflow flag and a flush.
// Optional feature macro: NIOS_DATA_OUT_IRQ_EN (irq port plus irq_en at addr 2).
module nios_data_out_ch1 #(
   parameter int unsigned DATA_W     = 10,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [DATA_W-1:0] out_port,
   output logic              out_valid,
   input  logic              out_ready
`ifdef NIOS_DATA_OUT_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] last_q, last_d;
   logic [31:0]       readdata_q, readdata_d;

   logic wr, pop, push_req, push_ok, flush, ovf_clr, empty, full;
   logic [31:0] status;

`ifdef NIOS_DATA_OUT_IRQ_EN
   logic irq_en_q, irq_en_d;
   logic irq_q, irq_d;
`endif

   // Only the low DATA_W bits and the two control bits carry meaning.
   logic unused_wd;
   assign unused_wd = ^writedata;

   // Head of the FIFO falls through to the stream side.
   assign out_port  = mem_q[rd_ptr_q];
   assign out_valid = ~empty;
   assign readdata  = readdata_q;
`ifdef NIOS_DATA_OUT_IRQ_EN
   assign irq = irq_q;
`endif

   // Next-state logic for FIFO, flags and read mux.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      last_d     = last_q;
      readdata_d = 32'h0;
      status     = 32'h0;

      empty    = (count_q == '0);
      full     = (count_q == CNT_W'(FIFO_DEPTH));
      wr       = chipselect & ~write_n;
      pop      = ~empty & out_ready;
      push_req = wr & (address == 2'd0);
      push_ok  = push_req & (~full | pop);
      flush    = wr & (address == 2'd1) & writedata[1];
      ovf_clr  = wr & (address == 2'd1) & writedata[0];

      if (push_ok) begin
         mem_d[wr_ptr_q] = writedata[DATA_W-1:0];
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         last_d          = writedata[DATA_W-1:0];
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push_ok && pop) count_d = count_q - CNT_W'(1);

      // Flush drops everything still queued; a same-cycle pop has completed.
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end

      // A rejected push wins over a same-cycle clear.
      if (ovf_clr)               ovf_d = 1'b0;
      if (push_req && !push_ok)  ovf_d = 1'b1;

      // Status reflects state before any same-cycle write.
      status[0]   = empty;
      status[1]   = full;
      status[2]   = ovf_q;
      status[7:4] = 4'(count_q);

      case (address)
         2'd0:    readdata_d = 32'(last_q);
         2'd1:    readdata_d = status;
`ifdef NIOS_DATA_OUT_IRQ_EN
         2'd2:    readdata_d = 32'(irq_en_q);
`endif
         default: readdata_d = 32'h0;
      endcase
   end

`ifdef NIOS_DATA_OUT_IRQ_EN
   // Interrupt enable register and registered irq.
   always_comb begin
      irq_en_d = irq_en_q;
      if (wr && (address == 2'd2)) irq_en_d = writedata[0];
      irq_d = irq_en_q & (empty | ovf_q);
   end

   // IRQ state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end
`endif

   // FIFO and register state.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         last_q     <= '0;
         readdata_q <= 32'h0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         last_q     <= last_d;
         readdata_q <= readdata_d;
      end
   end

endmodule
